// File: rtl/multicycle_ctrl32_if.sv
// Handshake and control bundle between the multicycle sequencer and its
// datapath and memories. master = sequencer side, slave = datapath/memory side.
interface multicycle_ctrl32_if #(
  parameter int INSTRET_W = 32
);
  logic [31:0]          instr_in;
  logic                 imem_ready;
  logic                 dmem_ready;
  logic                 zero;
  logic                 imem_req;
  logic                 ir_write;
  logic                 pc_write;
  logic [1:0]           pc_src;
  logic [1:0]           alu_op;
  logic                 alu_src;
  logic                 i_format;
  logic                 sftmd;
  logic                 jr;
  logic                 dmem_read;
  logic                 dmem_write;
  logic                 reg_write;
  logic [1:0]           reg_dst;
  logic [1:0]           mem_to_reg;
  logic                 instr_done;
  logic                 illegal;
  logic                 bus_err;
  logic [2:0]           state;
  logic [INSTRET_W-1:0] instret;

  modport master (
    input  instr_in, imem_ready, dmem_ready, zero,
    output imem_req, ir_write, pc_write, pc_src, alu_op, alu_src, i_format,
           sftmd, jr, dmem_read, dmem_write, reg_write, reg_dst, mem_to_reg,
           instr_done, illegal, bus_err, state, instret
  );

  modport slave (
    output instr_in, imem_ready, dmem_ready, zero,
    input  imem_req, ir_write, pc_write, pc_src, alu_op, alu_src, i_format,
           sftmd, jr, dmem_read, dmem_write, reg_write, reg_dst, mem_to_reg,
           instr_done, illegal, bus_err, state, instret
  );
endinterface

// File: rtl/multicycle_ctrl32.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the 32-bit MIPS-subset datapath,
// with memory-wait timeout and a retired-instruction counter.
module multicycle_ctrl32 #(
  parameter int INSTRET_W = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                clock,
  input  logic                reset,
  multicycle_ctrl32_if.master bus
);
  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [2:0]           state_reg, state_next;
  logic [5:0]           op_reg, op_next;
  logic [5:0]           func_reg, func_next;
  logic [CNT_W-1:0]     wait_cnt_reg, wait_cnt_next;
  logic [INSTRET_W-1:0] instret_reg, instret_next;

  logic retire, abort, ready_wait, limit_hit;
  logic is_r, is_jr, is_sft, is_j, is_jal, is_beq, is_bne, is_lw, is_sw;
  logic is_ifmt, supported;
  logic unused_instr_bits;

  // Only the opcode and function fields steer the sequencer.
  assign unused_instr_bits = ^bus.instr_in[25:6];

  assign is_r      = (op_reg == OP_RTYPE);
  assign is_jr     = is_r && (func_reg == FN_JR);
  assign is_sft    = is_r && (func_reg[5:3] == 3'b000);
  assign is_j      = (op_reg == OP_J);
  assign is_jal    = (op_reg == OP_JAL);
  assign is_beq    = (op_reg == OP_BEQ);
  assign is_bne    = (op_reg == OP_BNE);
  assign is_lw     = (op_reg == OP_LW);
  assign is_sw     = (op_reg == OP_SW);
  assign is_ifmt   = (op_reg[5:3] == 3'b001);
  assign supported = is_r | is_j | is_jal | is_beq | is_bne | is_lw | is_sw | is_ifmt;

  // Abort fires in the cycle whose wait would bring the count up to TIMEOUT.
  assign limit_hit = (TIMEOUT != 0) &&
                     ((32'(wait_cnt_reg) + 32'd1) == $unsigned(TIMEOUT));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IF;
      op_reg       <= '0;
      func_reg     <= '0;
      wait_cnt_reg <= '0;
      instret_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      func_reg     <= func_next;
      wait_cnt_reg <= wait_cnt_next;
      instret_reg  <= instret_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    func_next     = func_reg;
    retire        = 1'b0;
    abort         = 1'b0;
    ready_wait    = 1'b0;
    case (state_reg)
      S_IF: begin
        if (bus.imem_ready) begin
          op_next    = bus.instr_in[31:26];
          func_next  = bus.instr_in[5:0];
          state_next = S_ID;
        end else begin
          ready_wait = 1'b1;
          abort      = limit_hit;
        end
      end
      S_ID: begin
        if (is_j || is_jal || !supported) begin
          state_next = S_IF;
          retire     = 1'b1;
        end else begin
          state_next = S_EX;
        end
      end
      S_EX: begin
        if (is_beq || is_bne || is_jr) begin
          state_next = S_IF;
          retire     = 1'b1;
        end else if (is_lw || is_sw) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          if (is_lw) begin
            state_next = S_WB;
          end else begin
            state_next = S_IF;
            retire     = 1'b1;
          end
        end else begin
          ready_wait = 1'b1;
          if (limit_hit) begin
            abort      = 1'b1;
            state_next = S_IF;
          end
        end
      end
      S_WB: begin
        state_next = S_IF;
        retire     = 1'b1;
      end
      default: state_next = S_IF;
    endcase

    // The counter only runs in IF/MEM, so clearing on every transition is
    // equivalent to clearing on entry to those two states.
    wait_cnt_next = wait_cnt_reg;
    if (abort || (state_next != state_reg))
      wait_cnt_next = '0;
    else if (ready_wait)
      wait_cnt_next = wait_cnt_reg + CNT_W'(1);

    instret_next = instret_reg + INSTRET_W'(retire);
  end

  always_comb begin
    bus.imem_req   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 2'd0;
    bus.alu_op     = 2'b00;
    bus.alu_src    = 1'b0;
    bus.i_format   = 1'b0;
    bus.sftmd      = 1'b0;
    bus.jr         = 1'b0;
    bus.dmem_read  = 1'b0;
    bus.dmem_write = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 2'd0;
    bus.mem_to_reg = 2'd0;
    bus.illegal    = 1'b0;
    bus.instr_done = retire;
    bus.bus_err    = abort;

    // Execute controls stay valid through MEM so the address is stable.
    if (state_reg == S_EX || state_reg == S_MEM) begin
      bus.alu_op   = {is_r | is_ifmt, is_beq | is_bne};
      bus.alu_src  = is_ifmt | is_lw | is_sw;
      bus.i_format = is_ifmt;
      bus.sftmd    = is_sft;
      bus.jr       = is_jr;
    end

    case (state_reg)
      S_IF: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          bus.pc_src   = 2'd0;
        end
      end
      S_ID: begin
        if (is_j || is_jal) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = 2'd2;
        end
        if (is_jal) begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = 2'd2;
          bus.mem_to_reg = 2'd2;
        end
        bus.illegal = !supported;
      end
      S_EX: begin
        if (is_beq) begin
          bus.pc_write = bus.zero;
          bus.pc_src   = 2'd1;
        end else if (is_bne) begin
          bus.pc_write = ~bus.zero;
          bus.pc_src   = 2'd1;
        end else if (is_jr) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = 2'd3;
        end
      end
      S_MEM: begin
        bus.dmem_read  = is_lw;
        bus.dmem_write = is_sw;
      end
      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = is_r ? 2'd1 : 2'd0;
        bus.mem_to_reg = is_lw ? 2'd1 : 2'd0;
      end
      default: ;
    endcase
  end

  assign bus.state   = state_reg;
  assign bus.instret = instret_reg;

endmodule

// File: tb/tb_multicycle_ctrl32.sv
// Cycle-accurate bench for multicycle_ctrl32: each scenario queues per-cycle
// stimulus with the outputs expected in that cycle, then replays and compares.
`timescale 1ns/1ps
module tb_multicycle_ctrl32;
  localparam int INSTRET_W = 32;
  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4;

  typedef struct packed {
    logic [2:0] state;
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       i_format;
    logic       sftmd;
    logic       jr;
    logic       dmem_read;
    logic       dmem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       instr_done;
    logic       illegal;
    logic       bus_err;
  } obs_t;

  typedef struct packed {
    logic        imem_ready;
    logic        dmem_ready;
    logic        zero;
    logic [31:0] instr;
    obs_t        exp;
  } step_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  multicycle_ctrl32_if #(.INSTRET_W(INSTRET_W)) bus ();
  multicycle_ctrl32 #(.INSTRET_W(INSTRET_W), .TIMEOUT(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  obs_t obs;
  assign obs = {bus.state, bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src,
                bus.alu_op, bus.alu_src, bus.i_format, bus.sftmd, bus.jr,
                bus.dmem_read, bus.dmem_write, bus.reg_write, bus.reg_dst,
                bus.mem_to_reg, bus.instr_done, bus.illegal, bus.bus_err};

  step_t                sb[$];
  int                   total  = 0;
  int                   passed = 0;
  logic [INSTRET_W-1:0] exp_instret = '0;

  function automatic obs_t mk(input logic [2:0] st);
    obs_t e;
    e = '0;
    e.state    = st;
    e.imem_req = (st == S_IF);
    return e;
  endfunction

  function automatic step_t stp(input logic ir, input logic dr, input logic z,
                                input logic [31:0] ins, input obs_t e);
    step_t s;
    s.imem_ready = ir;
    s.dmem_ready = dr;
    s.zero       = z;
    s.instr      = ins;
    s.exp        = e;
    return s;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive_step(input step_t s);
    @(negedge clock);
    bus.imem_ready = s.imem_ready;
    bus.dmem_ready = s.dmem_ready;
    bus.zero       = s.zero;
    bus.instr_in   = s.instr;
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    reset = 1'b1;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.zero = 1'b0; bus.instr_in = '0;
    repeat (2) @(negedge clock);
    #1;
    e = mk(S_IF);
    total++;
    if (obs !== e) $display("FAIL reset outputs: got %h, want %h", obs, e);
    else passed++;
    total++;
    if (bus.instret !== '0) $display("FAIL reset instret: got %0d, want 0", bus.instret);
    else passed++;
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_add();
    obs_t e; step_t s;
    e = mk(S_IF); e.ir_write = 1; e.pc_write = 1;
    sb.push_back(stp(1'b1, 1'b0, 1'b0, 32'h00221820, e));
    e = mk(S_ID);                       sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    e = mk(S_EX); e.alu_op = 2'b10;     sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    e = mk(S_WB); e.reg_write = 1; e.reg_dst = 2'd1; e.instr_done = 1;
    sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    while (sb.size() != 0) begin
      s = sb.pop_front();
      drive_step(s);
      total++;
      if (obs !== s.exp) $display("FAIL add outputs: got %h, want %h", obs, s.exp);
      else passed++;
      total++;
      if (bus.instret !== exp_instret) $display("FAIL add instret: got %0d, want %0d", bus.instret, exp_instret);
      else passed++;
      if (s.exp.instr_done) exp_instret++;
    end
    $display("test_add done");
  endtask

  task automatic test_lw();
    obs_t e; step_t s;
    e = mk(S_IF); e.ir_write = 1; e.pc_write = 1;
    sb.push_back(stp(1'b1, 1'b0, 1'b0, 32'h8C220004, e));
    e = mk(S_ID);                   sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    e = mk(S_EX); e.alu_src = 1;    sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    for (int i = 0; i < 4; i++) begin
      e = mk(S_MEM); e.alu_src = 1; e.dmem_read = 1;
      sb.push_back(stp(1'b0, (i == 3), 1'b0, 32'h0, e));
    end
    e = mk(S_WB); e.reg_write = 1; e.mem_to_reg = 2'd1; e.instr_done = 1;
    sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    while (sb.size() != 0) begin
      s = sb.pop_front();
      drive_step(s);
      total++;
      if (obs !== s.exp) $display("FAIL lw outputs: got %h, want %h", obs, s.exp);
      else passed++;
      total++;
      if (bus.instret !== exp_instret) $display("FAIL lw instret: got %0d, want %0d", bus.instret, exp_instret);
      else passed++;
      if (s.exp.instr_done) exp_instret++;
    end
    $display("test_lw done");
  endtask

  task automatic test_branch();
    obs_t e; step_t s;
    logic [31:0] ins [3] = '{32'h10220003, 32'h10220003, 32'h14220003};
    logic        zv  [3] = '{1'b1, 1'b0, 1'b0};
    logic        pcw [3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      e = mk(S_IF); e.ir_write = 1; e.pc_write = 1;
      sb.push_back(stp(1'b1, 1'b0, 1'b0, ins[k], e));
      e = mk(S_ID); sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
      e = mk(S_EX); e.alu_op = 2'b01; e.pc_write = pcw[k]; e.pc_src = 2'd1; e.instr_done = 1;
      sb.push_back(stp(1'b0, 1'b0, zv[k], 32'h0, e));
    end
    while (sb.size() != 0) begin
      s = sb.pop_front();
      drive_step(s);
      total++;
      if (obs !== s.exp) $display("FAIL branch outputs: got %h, want %h", obs, s.exp);
      else passed++;
      total++;
      if (bus.instret !== exp_instret) $display("FAIL branch instret: got %0d, want %0d", bus.instret, exp_instret);
      else passed++;
      if (s.exp.instr_done) exp_instret++;
    end
    $display("test_branch done");
  endtask

  task automatic test_jump_illegal();
    obs_t e; step_t s;
    e = mk(S_IF); e.ir_write = 1; e.pc_write = 1;
    sb.push_back(stp(1'b1, 1'b0, 1'b0, 32'h0C000010, e));
    e = mk(S_ID); e.pc_write = 1; e.pc_src = 2'd2; e.reg_write = 1;
    e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; e.instr_done = 1;
    sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    e = mk(S_IF); e.ir_write = 1; e.pc_write = 1;
    sb.push_back(stp(1'b1, 1'b0, 1'b0, 32'h08000004, e));
    e = mk(S_ID); e.pc_write = 1; e.pc_src = 2'd2; e.instr_done = 1;
    sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    e = mk(S_IF); e.ir_write = 1; e.pc_write = 1;
    sb.push_back(stp(1'b1, 1'b0, 1'b0, 32'hFC000000, e));
    e = mk(S_ID); e.illegal = 1; e.instr_done = 1;
    sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    while (sb.size() != 0) begin
      s = sb.pop_front();
      drive_step(s);
      total++;
      if (obs !== s.exp) $display("FAIL jump outputs: got %h, want %h", obs, s.exp);
      else passed++;
      total++;
      if (bus.instret !== exp_instret) $display("FAIL jump instret: got %0d, want %0d", bus.instret, exp_instret);
      else passed++;
      if (s.exp.instr_done) exp_instret++;
    end
    $display("test_jump_illegal done");
  endtask

  task automatic test_back_to_back();
    obs_t e; step_t s;
    // addi $1,$2,5
    e = mk(S_IF); e.ir_write = 1; e.pc_write = 1;
    sb.push_back(stp(1'b1, 1'b0, 1'b0, 32'h20410005, e));
    e = mk(S_ID); sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    e = mk(S_EX); e.alu_op = 2'b10; e.alu_src = 1; e.i_format = 1;
    sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    e = mk(S_WB); e.reg_write = 1; e.instr_done = 1;
    sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    // sll $2,$2,2
    e = mk(S_IF); e.ir_write = 1; e.pc_write = 1;
    sb.push_back(stp(1'b1, 1'b0, 1'b0, 32'h00021080, e));
    e = mk(S_ID); sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    e = mk(S_EX); e.alu_op = 2'b10; e.sftmd = 1;
    sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    e = mk(S_WB); e.reg_write = 1; e.reg_dst = 2'd1; e.instr_done = 1;
    sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    // sw with memory ready immediately
    e = mk(S_IF); e.ir_write = 1; e.pc_write = 1;
    sb.push_back(stp(1'b1, 1'b0, 1'b0, 32'hAC220000, e));
    e = mk(S_ID); sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    e = mk(S_EX); e.alu_src = 1; sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    e = mk(S_MEM); e.alu_src = 1; e.dmem_write = 1; e.instr_done = 1;
    sb.push_back(stp(1'b0, 1'b1, 1'b0, 32'h0, e));
    // jr $31
    e = mk(S_IF); e.ir_write = 1; e.pc_write = 1;
    sb.push_back(stp(1'b1, 1'b0, 1'b0, 32'h03E00008, e));
    e = mk(S_ID); sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    e = mk(S_EX); e.alu_op = 2'b10; e.jr = 1; e.pc_write = 1; e.pc_src = 2'd3; e.instr_done = 1;
    sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    while (sb.size() != 0) begin
      s = sb.pop_front();
      drive_step(s);
      total++;
      if (obs !== s.exp) $display("FAIL back_to_back outputs: got %h, want %h", obs, s.exp);
      else passed++;
      total++;
      if (bus.instret !== exp_instret) $display("FAIL back_to_back instret: got %0d, want %0d", bus.instret, exp_instret);
      else passed++;
      if (s.exp.instr_done) exp_instret++;
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_timeout();
    obs_t e; step_t s;
    e = mk(S_IF); e.ir_write = 1; e.pc_write = 1;
    sb.push_back(stp(1'b1, 1'b0, 1'b0, 32'hAC220000, e));
    e = mk(S_ID); sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    e = mk(S_EX); e.alu_src = 1; sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    for (int i = 0; i < 4; i++) begin
      e = mk(S_MEM); e.alu_src = 1; e.dmem_write = 1; e.bus_err = (i == 3);
      sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    end
    // Instruction memory stalls too: fetch aborts on its fourth waiting cycle.
    for (int i = 0; i < 4; i++) begin
      e = mk(S_IF); e.bus_err = (i == 3);
      sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    end
    while (sb.size() != 0) begin
      s = sb.pop_front();
      drive_step(s);
      total++;
      if (obs !== s.exp) $display("FAIL timeout outputs: got %h, want %h", obs, s.exp);
      else passed++;
      total++;
      if (bus.instret !== exp_instret) $display("FAIL timeout instret: got %0d, want %0d", bus.instret, exp_instret);
      else passed++;
      if (s.exp.instr_done) exp_instret++;
    end
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid();
    obs_t e; step_t s;
    e = mk(S_IF); e.ir_write = 1; e.pc_write = 1;
    sb.push_back(stp(1'b1, 1'b0, 1'b0, 32'h8C220004, e));
    e = mk(S_ID); sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    e = mk(S_EX); e.alu_src = 1; sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    e = mk(S_MEM); e.alu_src = 1; e.dmem_read = 1;
    sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    while (sb.size() != 0) begin
      s = sb.pop_front();
      drive_step(s);
      total++;
      if (obs !== s.exp) $display("FAIL reset_mid outputs: got %h, want %h", obs, s.exp);
      else passed++;
      total++;
      if (bus.instret !== exp_instret) $display("FAIL reset_mid instret: got %0d, want %0d", bus.instret, exp_instret);
      else passed++;
      if (s.exp.instr_done) exp_instret++;
    end
    // Reset lands between clock edges while the load is still waiting.
    #2 reset = 1'b1;
    #1;
    total++;
    if (bus.state !== S_IF || bus.dmem_read !== 1'b0 || bus.imem_req !== 1'b1)
      $display("FAIL reset_mid async: got state %0d dmem_read %b imem_req %b, want 0 0 1",
               bus.state, bus.dmem_read, bus.imem_req);
    else passed++;
    total++;
    if (bus.instret !== '0) $display("FAIL reset_mid instret clear: got %0d, want 0", bus.instret);
    else passed++;
    exp_instret = '0;
    @(negedge clock);
    reset = 1'b0;
    e = mk(S_IF); e.ir_write = 1; e.pc_write = 1;
    sb.push_back(stp(1'b1, 1'b0, 1'b0, 32'h00221820, e));
    e = mk(S_ID); sb.push_back(stp(1'b0, 1'b0, 1'b0, 32'h0, e));
    while (sb.size() != 0) begin
      s = sb.pop_front();
      drive_step(s);
      total++;
      if (obs !== s.exp) $display("FAIL post_reset outputs: got %h, want %h", obs, s.exp);
      else passed++;
      total++;
      if (bus.instret !== exp_instret) $display("FAIL post_reset instret: got %0d, want %0d", bus.instret, exp_instret);
      else passed++;
      if (s.exp.instr_done) exp_instret++;
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_branch();
    test_jump_illegal();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
